// File: rtl/regfile_sb_if.sv
// Decode/write-back bus of the scoreboarded register file.
// Read data and busy flags are combinational; busy count is registered.
// No backpressure: decode stalls on its own when it sees a busy flag.
interface regfile_sb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [WIDTH-1:0]  PA;
  logic [WIDTH-1:0]  PB;
  logic [ADDR_W-1:0] RW;
  logic [WIDTH-1:0]  PW;
  logic              LE;
  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;
  logic              flush;
  logic              busy_a;
  logic              busy_b;
  logic [ADDR_W:0]   busy_cnt;

  // Pipeline side: decode/write-back drive addresses, data and scoreboard controls.
  modport master (
    output RA, RB, RW, PW, LE, mark_en, mark_addr, flush,
    input  PA, PB, busy_a, busy_b, busy_cnt
  );

  // Register file side.
  modport slave (
    input  RA, RB, RW, PW, LE, mark_en, mark_addr, flush,
    output PA, PB, busy_a, busy_b, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a per-register pending-write scoreboard.
// Reads and busy flags are zero latency; writes and busy updates land on the next edge.
// No backpressure: a same-cycle write may be bypassed to the read ports and masks busy.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_sb_if.slave   bus
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [ADDR_W:0]  r_busy_cnt;

  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]  w_cnt_nxt;
  logic             w_wr_ok;
  logic             w_mark_ok;
  logic             w_za;
  logic             w_zb;
  logic             w_byp_a;
  logic             w_byp_b;
  logic [WIDTH-1:0] w_pa;
  logic [WIDTH-1:0] w_pb;
  logic             w_busy_a;
  logic             w_busy_b;

  // Qualify writes/marks against the hardwired zero register and detect bypass hits.
  always_comb begin
    w_za      = (ZERO_REG != 0) && (bus.RA == '0);
    w_zb      = (ZERO_REG != 0) && (bus.RB == '0);
    w_wr_ok   = bus.LE && !((ZERO_REG != 0) && (bus.RW == '0));
    w_mark_ok = bus.mark_en && !((ZERO_REG != 0) && (bus.mark_addr == '0));
    w_byp_a   = (BYPASS != 0) && bus.LE && (bus.RW == bus.RA);
    w_byp_b   = (BYPASS != 0) && bus.LE && (bus.RW == bus.RB);
  end

  // Storage array; reset zeroes every entry so nothing reads X afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[bus.RW] <= bus.PW;
    end
  end

  // Read ports: zero register first, then same-cycle bypass, then the array.
  always_comb begin
    w_pa = r_mem[bus.RA];
    w_pb = r_mem[bus.RB];
    if (w_za) begin
      w_pa = '0;
    end else if (w_byp_a) begin
      w_pa = bus.PW;
    end
    if (w_zb) begin
      w_pb = '0;
    end else if (w_byp_b) begin
      w_pb = bus.PW;
    end
  end

  // Next busy vector: write-back clears, flush overrides, a new producer overrides both.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.LE) begin
      w_busy_nxt[bus.RW] = 1'b0;
    end
    if (bus.flush) begin
      w_busy_nxt = '0;
    end
    if (w_mark_ok) begin
      w_busy_nxt[bus.mark_addr] = 1'b1;
    end
  end

  // Population count of the next-state vector so simultaneous set/clear stays exact.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
    end
  end

  // Scoreboard state and its registered count advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  // Busy flags are masked for the zero register and for data bypassed this cycle.
  always_comb begin
    w_busy_a = r_busy[bus.RA] && !w_za && !w_byp_a;
    w_busy_b = r_busy[bus.RB] && !w_zb && !w_byp_b;
  end

  assign bus.PA       = w_pa;
  assign bus.PB       = w_pb;
  assign bus.busy_a   = w_busy_a;
  assign bus.busy_b   = w_busy_b;
  assign bus.busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default 32x32 build plus a 16x8 no-zero/no-bypass build.
// Checks against an array/bitmask model of the register and scoreboard rules.
// Inputs change 1ns after each rising edge; outputs are sampled 1ns later.
module tb_regfile_sb;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(32), .ADDR_W(5)) bus1 ();
  regfile_sb_if #(.WIDTH(16), .ADDR_W(3)) bus2 ();

  regfile_sb #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  regfile_sb #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  // Reference model: register contents and set of pending registers.
  logic [31:0] m1_mem [32];
  logic [31:0] m1_busy;
  logic [15:0] m2_mem [8];
  logic [7:0]  m2_busy;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m1_mem[i] = '0;
    for (int i = 0; i < 8; i++)  m2_mem[i] = '0;
    m1_busy = '0;
    m2_busy = '0;
  endtask

  // Expected read data / busy flag for the zero-register, bypassing build.
  function automatic logic [31:0] e1_rd(input int a);
    if (a == 0) return 32'h0;
    if (bus1.LE && int'(bus1.RW) == a) return bus1.PW;
    return m1_mem[a];
  endfunction

  function automatic logic e1_busy(input int a);
    if (a == 0) return 1'b0;
    if (bus1.LE && int'(bus1.RW) == a) return 1'b0;
    return m1_busy[a];
  endfunction

  // One clock edge: apply the write and scoreboard rules to the model.
  task automatic tick();
    logic [31:0] nb1;
    logic [7:0]  nb2;
    @(posedge clk);
    if (rst_n) begin
      nb1 = m1_busy;
      if (bus1.LE) nb1[bus1.RW] = 1'b0;
      if (bus1.flush) nb1 = '0;
      if (bus1.mark_en && bus1.mark_addr != 0) nb1[bus1.mark_addr] = 1'b1;
      if (bus1.LE && bus1.RW != 0) m1_mem[bus1.RW] = bus1.PW;
      m1_busy = nb1;
      nb2 = m2_busy;
      if (bus2.LE) nb2[bus2.RW] = 1'b0;
      if (bus2.flush) nb2 = '0;
      if (bus2.mark_en) nb2[bus2.mark_addr] = 1'b1;
      if (bus2.LE) m2_mem[bus2.RW] = bus2.PW;
      m2_busy = nb2;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle1();
    bus1.LE = 1'b0; bus1.mark_en = 1'b0; bus1.flush = 1'b0;
  endtask

  task automatic chk1_all(input string tag);
    chk({tag, ".PA"}, bus1.PA, e1_rd(int'(bus1.RA)));
    chk({tag, ".PB"}, bus1.PB, e1_rd(int'(bus1.RB)));
    chk({tag, ".busy_a"}, bus1.busy_a, e1_busy(int'(bus1.RA)));
    chk({tag, ".busy_b"}, bus1.busy_b, e1_busy(int'(bus1.RB)));
    chk({tag, ".cnt"}, bus1.busy_cnt, $countones(m1_busy));
  endtask

  task automatic chk2_all(input string tag);
    chk({tag, ".PA"}, bus2.PA, m2_mem[bus2.RA]);
    chk({tag, ".PB"}, bus2.PB, m2_mem[bus2.RB]);
    chk({tag, ".busy_a"}, bus2.busy_a, m2_busy[bus2.RA]);
    chk({tag, ".busy_b"}, bus2.busy_b, m2_busy[bus2.RB]);
    chk({tag, ".cnt"}, bus2.busy_cnt, $countones(m2_busy));
  endtask

  initial begin
    bus1.RA = '0; bus1.RB = '0; bus1.RW = '0; bus1.PW = '0;
    bus1.LE = 1'b0; bus1.mark_en = 1'b0; bus1.mark_addr = '0; bus1.flush = 1'b0;
    bus2.RA = '0; bus2.RB = '0; bus2.RW = '0; bus2.PW = '0;
    bus2.LE = 1'b0; bus2.mark_en = 1'b0; bus2.mark_addr = '0; bus2.flush = 1'b0;
    model_reset();

    // 1. Asynchronous reset between edges, then write/read-back.
    #2 rst_n = 1'b0;
    #1;
    chk("rst.PA", bus1.PA, 32'h0);
    chk("rst.PB", bus1.PB, 32'h0);
    chk("rst.cnt", bus1.busy_cnt, 6'd0);
    chk("rst.busy_a", bus1.busy_a, 1'b0);
    tick();
    rst_n = 1'b1;
    bus1.LE = 1'b1; bus1.RW = 5'd5; bus1.PW = 32'hDEADBEEF;
    tick();
    idle1(); bus1.RA = 5'd5;
    #1 chk("wr5.PA", bus1.PA, 32'hDEADBEEF);

    // 2. Zero register ignores writes; same-cycle bypass.
    bus1.LE = 1'b1; bus1.RW = 5'd0; bus1.PW = 32'hFFFFFFFF; bus1.RA = 5'd0;
    #1 chk("zero.now", bus1.PA, 32'h0);
    tick();
    idle1();
    #1 chk("zero.after", bus1.PA, 32'h0);
    bus1.LE = 1'b1; bus1.RW = 5'd7; bus1.PW = 32'h12345678; bus1.RB = 5'd7;
    #1 chk("byp.PB", bus1.PB, 32'h12345678);
    tick();
    idle1();

    // 3. Scoreboard lifecycle on r9.
    bus1.RA = 5'd9; bus1.mark_en = 1'b1; bus1.mark_addr = 5'd9;
    tick();
    idle1();
    #1 chk("mark9.busy_a", bus1.busy_a, 1'b1);
    chk("mark9.cnt", bus1.busy_cnt, 6'd1);
    bus1.LE = 1'b1; bus1.RW = 5'd9; bus1.PW = 32'hA5A5A5A5;
    #1 chk("wb9.busy_a", bus1.busy_a, 1'b0);
    chk("wb9.PA", bus1.PA, 32'hA5A5A5A5);
    tick();
    idle1();
    #1 chk("wb9.cnt", bus1.busy_cnt, 6'd0);

    // 4. Simultaneous write+mark, then flush+mark.
    bus1.mark_en = 1'b1; bus1.mark_addr = 5'd3; tick();
    bus1.mark_addr = 5'd4; tick();
    bus1.LE = 1'b1; bus1.RW = 5'd3; bus1.PW = 32'h33; bus1.mark_addr = 5'd3;
    tick();
    idle1(); bus1.RA = 5'd3;
    #1 chk("wm.busy3", bus1.busy_a, 1'b1);
    chk("wm.cnt", bus1.busy_cnt, 6'd2);
    bus1.flush = 1'b1; bus1.mark_en = 1'b1; bus1.mark_addr = 5'd6;
    tick();
    idle1(); bus1.RA = 5'd6; bus1.RB = 5'd4;
    #1 chk("fm.busy6", bus1.busy_a, 1'b1);
    chk("fm.busy4", bus1.busy_b, 1'b0);
    chk("fm.cnt", bus1.busy_cnt, 6'd1);

    // 5. Reset asserted in the middle of a write to r2.
    bus1.flush = 1'b1; bus1.LE = 1'b1; bus1.RW = 5'd2; bus1.PW = 32'h55;
    tick();
    idle1();
    for (int a = 1; a <= 3; a++) begin
      bus1.mark_en = 1'b1; bus1.mark_addr = 5'(a); tick();
    end
    idle1(); bus1.RA = 5'd2; bus1.RB = 5'd1;
    #1 chk("pre.cnt", bus1.busy_cnt, 6'd3);
    chk("pre.r2", bus1.PA, 32'h55);
    bus1.LE = 1'b1; bus1.RW = 5'd2; bus1.PW = 32'h77;
    #1 rst_n = 1'b0;
    model_reset();
    tick();
    idle1();
    #1 chk("mid.r2", bus1.PA, 32'h0);
    chk("mid.cnt", bus1.busy_cnt, 6'd0);
    chk("mid.busy_a", bus1.busy_a, 1'b0);
    chk("mid.busy_b", bus1.busy_b, 1'b0);
    rst_n = 1'b1;

    // Randomised traffic on the default build.
    for (int n = 0; n < 300; n++) begin
      bus1.RA = 5'($urandom); bus1.RB = 5'($urandom);
      bus1.RW = 5'($urandom); bus1.PW = $urandom;
      bus1.LE = 1'($urandom); bus1.mark_en = 1'($urandom);
      bus1.mark_addr = 5'($urandom);
      bus1.flush = ($urandom_range(0, 15) == 0);
      if (n % 4 == 1) bus1.RA = bus1.RW;
      if (n % 4 == 2) bus1.RB = bus1.RA;
      #1 chk1_all("rnd1");
      tick();
    end
    idle1();

    // 6. 16x8 build: register 0 is ordinary, no bypass.
    bus2.LE = 1'b1; bus2.RW = 3'd0; bus2.PW = 16'hBEEF;
    tick();
    bus2.LE = 1'b0; bus2.RA = 3'd0;
    #1 chk("p.r0", bus2.PA, 16'hBEEF);
    bus2.mark_en = 1'b1; bus2.mark_addr = 3'd0;
    tick();
    bus2.mark_en = 1'b0; bus2.LE = 1'b1; bus2.RW = 3'd0; bus2.PW = 16'h1234;
    #1 chk("p.old", bus2.PA, 16'hBEEF);
    chk("p.busy", bus2.busy_a, 1'b1);
    tick();
    bus2.LE = 1'b0;
    #1 chk("p.new", bus2.PA, 16'h1234);
    chk("p.clr", bus2.busy_a, 1'b0);
    for (int a = 0; a < 8; a++) begin
      bus2.mark_en = 1'b1; bus2.mark_addr = 3'(a); tick();
    end
    bus2.mark_en = 1'b0;
    #1 chk("p.cnt8", bus2.busy_cnt, 4'd8);
    for (int n = 0; n < 200; n++) begin
      bus2.RA = 3'($urandom); bus2.RB = 3'($urandom);
      bus2.RW = 3'($urandom); bus2.PW = 16'($urandom);
      bus2.LE = 1'($urandom); bus2.mark_en = 1'($urandom);
      bus2.mark_addr = 3'($urandom);
      bus2.flush = ($urandom_range(0, 15) == 0);
      if (n % 3 == 1) bus2.RA = bus2.RW;
      #1 chk2_all("rnd2");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
